datapath: RTL and testbench

DATAPATH -- requirements
Module: datapath

---
 rtl/datapath.sv | 164 ++++++++++++++++
 tb/tb_datapath.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath.sv
// 32-bit single-bus CPU datapath: register file, PC/HI/LO/MAR/MDR/Y/InPort, 64-bit Z and a combinational ALU.
// Define DATAPATH_MULDIV_EN to add signed MUL (01111) and DIV (10000); otherwise those opcodes load zero.
module datapath #(
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              R0in,  R1in,  R2in,  R3in,  R4in,  R5in,  R6in,  R7in,
    input  logic              R8in,  R9in,  R10in, R11in, R12in, R13in, R14in, R15in,
    input  logic              PCin,
    input  logic              HIin,
    input  logic              LOin,
    input  logic              MARin,
    input  logic              MDRin,
    input  logic              Yin,
    input  logic              Zin,
    input  logic              InPortIn,
    input  logic              R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
    input  logic              R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
    input  logic              PCout,
    input  logic              HIout,
    input  logic              LOout,
    input  logic              ZHighOut,
    input  logic              ZLowOut,
    input  logic              MDRout,
    input  logic              InPortOut,
    input  logic              incPC,
    input  logic              read,
    input  logic [4:0]        opcode,
    input  logic [DATA_W-1:0] Mdatain,
    input  logic [DATA_W-1:0] InPortData,
    output logic [DATA_W-1:0] BusMuxOut,
    output logic [DATA_W-1:0] MARout
);

    localparam logic [4:0] OP_ADD = 5'b00011;
    localparam logic [4:0] OP_SUB = 5'b00100;
    localparam logic [4:0] OP_AND = 5'b00101;
    localparam logic [4:0] OP_OR  = 5'b00110;
    localparam logic [4:0] OP_SHR = 5'b00111;
    localparam logic [4:0] OP_SHL = 5'b01000;
    localparam logic [4:0] OP_ROR = 5'b01001;
    localparam logic [4:0] OP_ROL = 5'b01010;
    localparam logic [4:0] OP_NEG = 5'b10001;
    localparam logic [4:0] OP_NOT = 5'b10010;
`ifdef DATAPATH_MULDIV_EN
    localparam logic [4:0] OP_MUL = 5'b01111;
    localparam logic [4:0] OP_DIV = 5'b10000;
`endif

    logic [15:0]         r_in;
    logic [15:0]         r_out;
    logic [DATA_W-1:0]   gpr [16];
    logic [DATA_W-1:0]   pc, hi, lo, mar, mdr, y, inport, z_hi, z_lo;
    logic [DATA_W-1:0]   bus;

    logic signed [DATA_W-1:0]   alu_a, alu_b;
    logic [DATA_W-1:0]          alu_lo, alu_hi;
    logic [4:0]                 sh;
    logic [2*DATA_W-1:0]        rot;

    assign r_in  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                    R7in,  R6in,  R5in,  R4in,  R3in,  R2in,  R1in, R0in};
    assign r_out = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                    R7out,  R6out,  R5out,  R4out,  R3out,  R2out,  R1out, R0out};

    // Bus source mux: lowest-numbered GPR wins, then the fixed special-register order.
    always_comb begin
        bus = '0;
        if (|r_out) begin
            for (int i = 15; i >= 0; i--) begin
                if (r_out[i]) bus = gpr[i];
            end
        end else if (HIout)     bus = hi;
        else if (LOout)         bus = lo;
        else if (ZHighOut)      bus = z_hi;
        else if (ZLowOut)       bus = z_lo;
        else if (PCout)         bus = pc;
        else if (MDRout)        bus = mdr;
        else if (InPortOut)     bus = inport;
    end

    assign BusMuxOut = bus;
    assign MARout    = mar;

    assign alu_a = $signed(y);
    assign alu_b = $signed(bus);
    assign sh    = alu_b[4:0];

`ifdef DATAPATH_MULDIV_EN
    logic signed [2*DATA_W-1:0] prod;
    logic signed [DATA_W-1:0]   quot, rem;

    assign prod = $signed({{DATA_W{alu_a[DATA_W-1]}}, alu_a}) *
                  $signed({{DATA_W{alu_b[DATA_W-1]}}, alu_b});
    assign quot = (alu_b == '0) ? '0 : alu_a / alu_b;
    assign rem  = (alu_b == '0) ? '0 : alu_a % alu_b;
`endif

    // Rotates use a doubled operand so a zero amount needs no special case.
    always_comb begin
        alu_lo = '0;
        alu_hi = '0;
        rot    = '0;
        case (opcode)
            OP_ADD: alu_lo = alu_a + alu_b;
            OP_SUB: alu_lo = alu_a - alu_b;
            OP_AND: alu_lo = alu_a & alu_b;
            OP_OR:  alu_lo = alu_a | alu_b;
            OP_SHR: alu_lo = alu_a >> sh;
            OP_SHL: alu_lo = alu_a << sh;
            OP_ROR: begin
                rot    = {alu_a, alu_a} >> sh;
                alu_lo = rot[DATA_W-1:0];
            end
            OP_ROL: begin
                rot    = {alu_a, alu_a} << sh;
                alu_lo = rot[2*DATA_W-1:DATA_W];
            end
            OP_NEG: alu_lo = -alu_b;
            OP_NOT: alu_lo = ~alu_b;
`ifdef DATAPATH_MULDIV_EN
            OP_MUL: {alu_hi, alu_lo} = prod;
            OP_DIV: begin
                alu_lo = quot;
                alu_hi = rem;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < 16; i++) gpr[i] <= '0;
            pc     <= '0;
            hi     <= '0;
            lo     <= '0;
            mar    <= '0;
            mdr    <= '0;
            y      <= '0;
            inport <= '0;
            z_hi   <= '0;
            z_lo   <= '0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (r_in[i]) gpr[i] <= bus;
            end
            if (incPC)          pc <= pc + 1'b1;
            else if (PCin)      pc <= bus;
            if (HIin)           hi <= bus;
            if (LOin)           lo <= bus;
            if (MARin)          mar <= bus;
            if (MDRin)          mdr <= read ? Mdatain : bus;
            if (Yin)            y <= bus;
            if (InPortIn)       inport <= InPortData;
            if (Zin) begin
                z_hi <= alu_hi;
                z_lo <= alu_lo;
            end
        end
    end

endmodule

// File: tb/tb_datapath.sv
// Directed and randomized bench for the datapath; expectations come from a plain-arithmetic ALU model.
`timescale 1ns/1ps
module tb_datapath;

    localparam int S_HI = 16, S_LO = 17, S_ZH = 18, S_ZL = 19, S_PC = 20, S_MDR = 21, S_IN = 22;
    localparam int D_PC = 20, D_HI = 16, D_LO = 17, D_MAR = 23, D_MDR = 21, D_Y = 24;

    logic        clock = 1'b0;
    logic        clear;
    logic [15:0] rin, rout;
    logic        PCin, HIin, LOin, MARin, MDRin, Yin, Zin, InPortIn;
    logic        PCout, HIout, LOout, ZHighOut, ZLowOut, MDRout, InPortOut;
    logic        incPC, read;
    logic [4:0]  opcode;
    logic [31:0] Mdatain, InPortData;
    logic [31:0] BusMuxOut, MARout;

    int total = 0;
    int bad   = 0;

    logic [4:0] ops [0:14] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10,
                               5'd17, 5'd18, 5'd15, 5'd16, 5'd0, 5'd31, 5'd12};

    always #5 clock = ~clock;

    datapath dut (
        .clock(clock), .clear(clear),
        .R0in(rin[0]), .R1in(rin[1]), .R2in(rin[2]), .R3in(rin[3]),
        .R4in(rin[4]), .R5in(rin[5]), .R6in(rin[6]), .R7in(rin[7]),
        .R8in(rin[8]), .R9in(rin[9]), .R10in(rin[10]), .R11in(rin[11]),
        .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
        .PCin(PCin), .HIin(HIin), .LOin(LOin), .MARin(MARin), .MDRin(MDRin),
        .Yin(Yin), .Zin(Zin), .InPortIn(InPortIn),
        .R0out(rout[0]), .R1out(rout[1]), .R2out(rout[2]), .R3out(rout[3]),
        .R4out(rout[4]), .R5out(rout[5]), .R6out(rout[6]), .R7out(rout[7]),
        .R8out(rout[8]), .R9out(rout[9]), .R10out(rout[10]), .R11out(rout[11]),
        .R12out(rout[12]), .R13out(rout[13]), .R14out(rout[14]), .R15out(rout[15]),
        .PCout(PCout), .HIout(HIout), .LOout(LOout), .ZHighOut(ZHighOut),
        .ZLowOut(ZLowOut), .MDRout(MDRout), .InPortOut(InPortOut),
        .incPC(incPC), .read(read), .opcode(opcode),
        .Mdatain(Mdatain), .InPortData(InPortData),
        .BusMuxOut(BusMuxOut), .MARout(MARout)
    );

    function automatic logic [63:0] ref_alu(logic [4:0] op, logic [31:0] a, logic [31:0] b);
        logic [31:0] r;
        int s;
        int sa, sb;
        longint p;
        s  = int'(b[4:0]);
        sa = a;
        sb = b;
        r  = '0;
        case (op)
            5'd3:  r = a + b;
            5'd4:  r = a - b;
            5'd5:  r = a & b;
            5'd6:  r = a | b;
            5'd7:  r = a >> s;
            5'd8:  r = a << s;
            5'd9:  begin r = a; repeat (s) r = {r[0], r[31:1]}; end
            5'd10: begin r = a; repeat (s) r = {r[30:0], r[31]}; end
            5'd17: r = 32'd0 - b;
            5'd18: r = ~b;
`ifdef DATAPATH_MULDIV_EN
            5'd15: begin
                p = longint'(sa) * longint'(sb);
                return p;
            end
            5'd16: begin
                if (sb == 0) return 64'd0;
                return {32'(sa % sb), 32'(sa / sb)};
            end
`endif
            default: r = '0;
        endcase
        return {32'd0, r};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rin = '0; rout = '0;
        PCin = 0; HIin = 0; LOin = 0; MARin = 0; MDRin = 0; Yin = 0; Zin = 0; InPortIn = 0;
        PCout = 0; HIout = 0; LOout = 0; ZHighOut = 0; ZLowOut = 0; MDRout = 0; InPortOut = 0;
        incPC = 0; read = 0; opcode = '0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        idle();
    endtask

    task automatic src(input int s);
        if (s < 16) rout[s] = 1'b1;
        else case (s)
            S_HI:  HIout = 1;
            S_LO:  LOout = 1;
            S_ZH:  ZHighOut = 1;
            S_ZL:  ZLowOut = 1;
            S_PC:  PCout = 1;
            S_MDR: MDRout = 1;
            default: InPortOut = 1;
        endcase
    endtask

    task automatic dst(input int d);
        if (d < 16) rin[d] = 1'b1;
        else case (d)
            D_HI:  HIin = 1;
            D_LO:  LOin = 1;
            D_PC:  PCin = 1;
            D_MAR: MARin = 1;
            D_MDR: MDRin = 1;
            default: Yin = 1;
        endcase
    endtask

    task automatic look(input int s, input string tag, input logic [31:0] exp);
        idle();
        src(s);
        #1;
        chk(tag, {32'd0, BusMuxOut}, {32'd0, exp});
        idle();
    endtask

    task automatic put(input int d, input logic [31:0] v);
        Mdatain = v; read = 1; MDRin = 1;
        tick();
        if (d != D_MDR) begin
            src(S_MDR); dst(d);
            tick();
        end
    endtask

    task automatic alu_op(input logic [4:0] op, input int s);
        src(s); opcode = op; Zin = 1;
        tick();
    endtask

    initial begin
        logic [31:0] a, b;
        logic [63:0] e;
        logic [4:0]  op;
        int k;

        idle();
        Mdatain = '0; InPortData = '0;
        clear = 1'b0;
        #2;
        chk("rst_bus", {32'd0, BusMuxOut}, 64'd0);
        chk("rst_mar", {32'd0, MARout}, 64'd0);
        #10;
        clear = 1'b1;
        look(S_PC, "rst_pc", 32'd0);
        look(S_ZL, "rst_zlo", 32'd0);
        look(9, "rst_r9", 32'd0);

        // Add two values fetched from memory.
        put(4, 32'd30);
        put(3, 32'd25);
        src(4); Yin = 1; tick();
        alu_op(5'd3, 3);
        src(S_ZL); rin[7] = 1; tick();
        look(7, "add_r7", 32'd55);
        look(S_ZH, "add_zhi", 32'd0);

        // PC fetch step, then incPC over PCin.
        src(S_PC); MARin = 1; incPC = 1;
        #1;
        chk("fetch_bus", {32'd0, BusMuxOut}, 64'd0);
        tick();
        chk("fetch_mar", {32'd0, MARout}, 64'd0);
        look(S_PC, "pc_inc", 32'd1);
        src(S_MDR); PCin = 1; incPC = 1; tick();
        look(S_PC, "pc_prio", 32'd2);
        src(S_MDR); PCin = 1; tick();
        look(S_PC, "pc_load", 32'd25);

        // Load-and-drive: old value on the bus, new value next cycle.
        Mdatain = 32'd99; read = 1; MDRin = 1; MDRout = 1;
        #1;
        chk("lnd_old", {32'd0, BusMuxOut}, 64'd25);
        tick();
        look(S_MDR, "lnd_new", 32'd99);
        src(4); MDRin = 1; read = 0; tick();
        look(S_MDR, "mdr_bus", 32'd30);

        // ALU boundaries.
        put(1, 32'd1);
        put(D_Y, 32'hFFFF_FFFF);
        alu_op(5'd3, 1);
        look(S_ZL, "add_wrap", 32'd0);
        look(S_ZH, "add_wrap_hi", 32'd0);
        put(D_Y, 32'd0);
        alu_op(5'd4, 1);
        look(S_ZL, "sub_wrap", 32'hFFFF_FFFF);
        put(D_Y, 32'h8000_0001);
        alu_op(5'd10, 1);
        look(S_ZL, "rol1", 32'h0000_0003);
        alu_op(5'd9, 1);
        look(S_ZL, "ror1", 32'hC000_0000);

        // Bus priority.
        put(2, 32'd5);
        put(9, 32'd7);
        src(2); src(9); #1;
        chk("prio_r2r9", {32'd0, BusMuxOut}, 64'd5);
        idle(); #1;
        chk("no_src", {32'd0, BusMuxOut}, 64'd0);
        put(D_HI, 32'hAAAA);
        put(D_LO, 32'hBBBB);
        src(S_HI); src(S_LO); src(9); #1;
        chk("prio_r9_hi", {32'd0, BusMuxOut}, 64'd7);
        idle(); src(S_HI); src(S_LO); #1;
        chk("prio_hi_lo", {32'd0, BusMuxOut}, 64'hAAAA);
        idle(); src(S_LO); src(S_PC); src(S_MDR); #1;
        chk("prio_lo_pc", {32'd0, BusMuxOut}, 64'hBBBB);
        idle();
        InPortData = 32'hDEAD_BEEF; InPortIn = 1; tick();
        look(S_IN, "inport", 32'hDEAD_BEEF);

`ifdef DATAPATH_MULDIV_EN
        put(1, 32'd7);
        put(D_Y, 32'hFFFF_FFFD);
        alu_op(5'd15, 1);
        look(S_ZH, "mul_hi", 32'hFFFF_FFFF);
        look(S_ZL, "mul_lo", 32'hFFFF_FFEB);
        put(1, 32'd5);
        put(D_Y, 32'd17);
        alu_op(5'd16, 1);
        look(S_ZL, "div_q", 32'd3);
        look(S_ZH, "div_r", 32'd2);
        put(1, 32'd0);
        alu_op(5'd16, 1);
        look(S_ZL, "div0_lo", 32'd0);
        look(S_ZH, "div0_hi", 32'd0);
`else
        put(1, 32'd7);
        put(D_Y, 32'd5);
        alu_op(5'd15, 1);
        look(S_ZL, "mul_off_lo", 32'd0);
        look(S_ZH, "mul_off_hi", 32'd0);
        alu_op(5'd16, 1);
        look(S_ZL, "div_off_lo", 32'd0);
`endif

        // Randomized ALU and register-load checks.
        for (int it = 0; it < 40; it++) begin
            a  = $urandom;
            b  = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40));
            op = ops[$urandom_range(0, 14)];
            k  = $urandom_range(0, 15);
            put(D_Y, a);
            InPortData = b; InPortIn = 1; tick();
            src(S_IN); opcode = op; Zin = 1; dst(k); tick();
            e = ref_alu(op, a, b);
            look(S_ZL, $sformatf("rnd%0d_op%0d_zlo", it, op), e[31:0]);
            look(S_ZH, $sformatf("rnd%0d_op%0d_zhi", it, op), e[63:32]);
            look(k, $sformatf("rnd%0d_r%0d", it, k), b);
        end

        // Asynchronous clear between edges, then held across an edge.
        put(5, 32'h1234);
        put(D_Y, 32'h10);
        alu_op(5'd6, 5);
        incPC = 1; tick();
        look(S_ZL, "pre_clr_z", 32'h1234);
        #2;
        clear = 1'b0;
        #1;
        look(5, "clr_r5", 32'd0);
        look(S_ZL, "clr_zlo", 32'd0);
        look(S_PC, "clr_pc", 32'd0);
        look(S_HI, "clr_hi", 32'd0);
        chk("clr_mar", {32'd0, MARout}, 64'd0);
        InPortData = 32'h5555; InPortIn = 1; src(S_IN); rin[5] = 1; incPC = 1; Zin = 1; opcode = 5'd18;
        @(posedge clock); #1;
        look(5, "clr_hold_r5", 32'd0);
        look(S_PC, "clr_hold_pc", 32'd0);
        look(S_ZL, "clr_hold_z", 32'd0);
        look(S_IN, "clr_hold_in", 32'd0);
        #2;
        clear = 1'b1;
        put(6, 32'hCAFE);
        look(6, "post_clr", 32'hCAFE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
